// File: rtl/riscv.sv
// Core-wide RISC-V constants shared by frontend and execute.
// VLEN is the virtual address width carried with branch pcs.
package riscv;
  localparam int unsigned VLEN = 64;
endpackage

// File: rtl/pbp_resolve_queue.sv
// Perceptron predictor resolve queue: pairs in-order predictions with
// execute resolutions and emits training and GHR repair packets.
module pbp_resolve_queue
  import riscv::*;
#(
  parameter int GHR_LENGTH = 10,
  parameter int DEPTH      = 8,
  parameter int SUM_W      = 16,
  parameter int THETA      = 33
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         debug_mode_i,
  input  logic                         pred_valid_i,
  output logic                         pred_ready_o,
  input  logic [VLEN-1:0]              pred_pc_i,
  input  logic                         pred_taken_i,
  input  logic signed [SUM_W-1:0]      pred_sum_i,
  input  logic [GHR_LENGTH-1:0]        pred_history_i,
  input  logic                         res_valid_i,
  output logic                         res_ready_o,
  input  logic                         res_taken_i,
  output logic                         upd_valid_o,
  output logic [VLEN-1:0]              upd_pc_o,
  output logic                         upd_is_mispredict_o,
  output logic                         upd_taken_o,
  output logic [GHR_LENGTH-1:0]        upd_history_o,
  output logic                         ghr_restore_valid_o,
  output logic [GHR_LENGTH-1:0]        ghr_restore_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [VLEN-1:0]         pc;
    logic                    taken;
    logic signed [SUM_W-1:0] sum;
    logic [GHR_LENGTH-1:0]   history;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, mis, train;
  entry_t        head;
  logic signed [SUM_W:0] sum_x;
  logic [SUM_W:0]        sum_abs;

  assign pred_ready_o = (cnt_q != CW'(DEPTH));
  assign res_ready_o  = (cnt_q != '0);
  assign count_o      = cnt_q;

  always_comb begin
    head  = mem[rd_q];
    push  = pred_valid_i & pred_ready_o;
    pop   = res_valid_i & res_ready_o;
    mis   = head.taken ^ res_taken_i;
    // Widen before negating so the most negative sum stays positive
    sum_x   = {head.sum[SUM_W-1], head.sum};
    sum_abs = sum_x[SUM_W] ? -sum_x : sum_x;
    train   = !debug_mode_i & (mis | (sum_abs <= (SUM_W+1)'(THETA)));
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end else if (pop && mis) begin
      rd_d  = rd_q + 1'b1;
      wr_d  = rd_q + 1'b1;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_q] <= '{pc: pred_pc_i, taken: pred_taken_i,
                     sum: pred_sum_i, history: pred_history_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q                <= '0;
      rd_q                <= '0;
      cnt_q               <= '0;
      upd_valid_o         <= 1'b0;
      upd_pc_o            <= '0;
      upd_is_mispredict_o <= 1'b0;
      upd_taken_o         <= 1'b0;
      upd_history_o       <= '0;
      ghr_restore_valid_o <= 1'b0;
      ghr_restore_o       <= '0;
    end else begin
      wr_q                <= wr_d;
      rd_q                <= rd_d;
      cnt_q               <= cnt_d;
      upd_valid_o         <= pop & train;
      ghr_restore_valid_o <= pop & mis;
      if (pop) begin
        upd_pc_o            <= head.pc;
        upd_is_mispredict_o <= mis;
        upd_taken_o         <= res_taken_i;
        upd_history_o       <= head.history;
        ghr_restore_o       <= {head.history[GHR_LENGTH-2:0], res_taken_i};
      end
    end
  end

endmodule

// File: tb/tb_pbp_resolve_queue.sv
// Directed bench for pbp_resolve_queue with hand-computed expectations.
module tb_pbp_resolve_queue;
  localparam int GL = 10;
  localparam int DEPTH = 8;
  localparam int SW = 16;

  logic clk_i = 0;
  logic rst_ni = 0;
  logic flush_i = 0;
  logic debug_mode_i = 0;
  logic pred_valid_i = 0;
  logic pred_ready_o;
  logic [63:0] pred_pc_i = '0;
  logic pred_taken_i = 0;
  logic signed [SW-1:0] pred_sum_i = '0;
  logic [GL-1:0] pred_history_i = '0;
  logic res_valid_i = 0;
  logic res_ready_o;
  logic res_taken_i = 0;
  logic upd_valid_o;
  logic [63:0] upd_pc_o;
  logic upd_is_mispredict_o;
  logic upd_taken_o;
  logic [GL-1:0] upd_history_o;
  logic ghr_restore_valid_o;
  logic [GL-1:0] ghr_restore_o;
  logic [3:0] count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pbp_resolve_queue #(.GHR_LENGTH(GL), .DEPTH(DEPTH),
                      .SUM_W(SW), .THETA(33)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .debug_mode_i(debug_mode_i),
    .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
    .pred_pc_i(pred_pc_i), .pred_taken_i(pred_taken_i),
    .pred_sum_i(pred_sum_i), .pred_history_i(pred_history_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_taken_i(res_taken_i),
    .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o),
    .upd_is_mispredict_o(upd_is_mispredict_o),
    .upd_taken_o(upd_taken_o), .upd_history_o(upd_history_o),
    .ghr_restore_valid_o(ghr_restore_valid_o),
    .ghr_restore_o(ghr_restore_o), .count_o(count_o)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_pred(input logic [63:0] pc, input logic t,
                          input logic signed [SW-1:0] s,
                          input logic [GL-1:0] h);
    pred_valid_i = 1;
    pred_pc_i = pc;
    pred_taken_i = t;
    pred_sum_i = s;
    pred_history_i = h;
  endtask

  task automatic push(input logic [63:0] pc, input logic t,
                      input logic signed [SW-1:0] s,
                      input logic [GL-1:0] h);
    set_pred(pc, t, s, h);
    tick();
    pred_valid_i = 0;
  endtask

  task automatic pop(input logic t);
    res_valid_i = 1;
    res_taken_i = t;
    tick();
    res_valid_i = 0;
  endtask

  task automatic train_case(input string tag, input logic signed [SW-1:0] s,
                            input logic exp);
    push(64'h90, 1'b0, s, 10'h155);
    pop(1'b0);
    check({tag, "_valid"}, upd_valid_o, exp);
    check({tag, "_mis"}, upd_is_mispredict_o, 0);
  endtask

  initial begin
    #2;
    check("rst_count", count_o, 0);
    check("rst_pready", pred_ready_o, 1);
    check("rst_rready", res_ready_o, 0);
    check("rst_uvalid", upd_valid_o, 0);
    check("rst_gvalid", ghr_restore_valid_o, 0);
    tick();
    rst_ni = 1;
    tick();

    push(64'h80, 1'b1, 16'sd50, 10'h2AA);
    check("t1_count1", count_o, 1);
    check("t1_rready", res_ready_o, 1);
    pop(1'b1);
    check("t1_uvalid", upd_valid_o, 0);
    check("t1_gvalid", ghr_restore_valid_o, 0);
    check("t1_count0", count_o, 0);
    check("t1_pc", upd_pc_o, 64'h80);

    train_case("sum_m10", -16'sd10, 1);
    check("t2_hist", upd_history_o, 10'h155);
    check("t2_gvalid", ghr_restore_valid_o, 0);
    train_case("sum_m33", -16'sd33, 1);
    train_case("sum_m34", -16'sd34, 0);
    train_case("sum_p33", 16'sd33, 1);
    train_case("sum_p34", 16'sd34, 0);
    train_case("sum_min", 16'sh8000, 0);

    push(64'h100, 1'b1, 16'sd100, 10'h3FF);
    push(64'h104, 1'b0, 16'sd100, 10'h3FF);
    push(64'h108, 1'b0, 16'sd100, 10'h3FF);
    check("t3_count3", count_o, 3);
    pop(1'b0);
    check("t3_mis", upd_is_mispredict_o, 1);
    check("t3_uvalid", upd_valid_o, 1);
    check("t3_pc", upd_pc_o, 64'h100);
    check("t3_taken", upd_taken_o, 0);
    check("t3_gvalid", ghr_restore_valid_o, 1);
    check("t3_restore", ghr_restore_o, 10'h3FE);
    check("t3_count", count_o, 0);
    check("t3_rready", res_ready_o, 0);
    tick();
    check("t3_pulse", ghr_restore_valid_o, 0);

    for (int i = 0; i < DEPTH; i++)
      push(64'h200 + 64'(4 * i), 1'b1, 16'sd100, GL'(i));
    check("t4_full", pred_ready_o, 0);
    check("t4_count8", count_o, 8);
    push(64'h999, 1'b1, 16'sd100, 10'h0);
    check("t4_drop", count_o, 8);
    set_pred(64'h300, 1'b1, 16'sd100, 10'h0);
    res_valid_i = 1;
    res_taken_i = 1;
    tick();
    pred_valid_i = 0;
    res_valid_i = 0;
    check("t4_count7", count_o, 7);
    check("t4_pc0", upd_pc_o, 64'h200);
    for (int i = 1; i < DEPTH; i++) begin
      pop(1'b1);
      check($sformatf("t4_pc%0d", i), upd_pc_o, 64'h200 + 64'(4 * i));
    end
    check("t4_empty", count_o, 0);

    push(64'h1000, 1'b1, 16'sd100, 10'h0);
    for (int i = 1; i < 20; i++) begin
      set_pred(64'h1000 + 64'(4 * i), 1'b1, 16'sd100, 10'h0);
      res_valid_i = 1;
      res_taken_i = 1;
      tick();
      pred_valid_i = 0;
      res_valid_i = 0;
      check($sformatf("wrap_pc%0d", i), upd_pc_o,
            64'h1000 + 64'(4 * (i - 1)));
      check($sformatf("wrap_cnt%0d", i), count_o, 1);
    end
    pop(1'b1);
    check("wrap_last", upd_pc_o, 64'h1000 + 64'(4 * 19));

    push(64'h400, 1'b1, 16'sd100, 10'h001);
    push(64'h404, 1'b1, 16'sd100, 10'h001);
    set_pred(64'h500, 1'b1, 16'sd100, 10'h0);
    res_valid_i = 1;
    res_taken_i = 0;
    flush_i = 1;
    tick();
    pred_valid_i = 0;
    res_valid_i = 0;
    flush_i = 0;
    check("t5_uvalid", upd_valid_o, 1);
    check("t5_mis", upd_is_mispredict_o, 1);
    check("t5_pc", upd_pc_o, 64'h400);
    check("t5_gvalid", ghr_restore_valid_o, 1);
    check("t5_restore", ghr_restore_o, 10'h002);
    check("t5_count", count_o, 0);
    check("t5_rready", res_ready_o, 0);
    push(64'h600, 1'b1, 16'sd100, 10'h0);
    pop(1'b1);
    check("t5_next", upd_pc_o, 64'h600);

    debug_mode_i = 1;
    push(64'h700, 1'b1, 16'sd0, 10'h0F0);
    pop(1'b0);
    check("t6_uvalid", upd_valid_o, 0);
    check("t6_gvalid", ghr_restore_valid_o, 1);
    check("t6_restore", ghr_restore_o, 10'h1E0);
    check("t6_count", count_o, 0);
    debug_mode_i = 0;
    pop(1'b1);
    check("t6_empty_uv", upd_valid_o, 0);
    check("t6_empty_gv", ghr_restore_valid_o, 0);
    check("t6_empty_cnt", count_o, 0);
    check("t6_empty_pc", upd_pc_o, 64'h700);

    push(64'h800, 1'b1, 16'sd0, 10'h0);
    push(64'h804, 1'b1, 16'sd0, 10'h0);
    rst_ni = 0;
    #1;
    check("mrst_count", count_o, 0);
    check("mrst_rready", res_ready_o, 0);
    check("mrst_pready", pred_ready_o, 1);
    tick();
    rst_ni = 1;
    tick();
    check("mrst_uvalid", upd_valid_o, 0);
    check("mrst_gvalid", ghr_restore_valid_o, 0);
    check("mrst_pc", upd_pc_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
